// File: rtl/btd_pkg.sv
// Shared constants for the signed seven-segment encoder/decoder pair.
// This package is the single source of the 16-entry segment code set.
package btd_pkg;
    localparam int SEG_W = 7;
    localparam int VAL_W = 5;

    localparam logic [SEG_W-1:0] SEG_CODE_0  = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_CODE_1  = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_CODE_2  = 7'b1011101;
    localparam logic [SEG_W-1:0] SEG_CODE_3  = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_CODE_4  = 7'b0111010;
    localparam logic [SEG_W-1:0] SEG_CODE_5  = 7'b1101011;
    localparam logic [SEG_W-1:0] SEG_CODE_6  = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_CODE_7  = 7'b1010010;
    localparam logic [SEG_W-1:0] SEG_CODE_8  = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_CODE_9  = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_CODE_10 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_CODE_11 = 7'b0101111;
    localparam logic [SEG_W-1:0] SEG_CODE_12 = 7'b1100101;
    localparam logic [SEG_W-1:0] SEG_CODE_13 = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_CODE_14 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_CODE_15 = 7'b1101100;

    // Indexed view of the code set so generate loops can walk it.
    function automatic logic [SEG_W-1:0] seg_code(input int idx);
        case (idx)
            0:       return SEG_CODE_0;
            1:       return SEG_CODE_1;
            2:       return SEG_CODE_2;
            3:       return SEG_CODE_3;
            4:       return SEG_CODE_4;
            5:       return SEG_CODE_5;
            6:       return SEG_CODE_6;
            7:       return SEG_CODE_7;
            8:       return SEG_CODE_8;
            9:       return SEG_CODE_9;
            10:      return SEG_CODE_10;
            11:      return SEG_CODE_11;
            12:      return SEG_CODE_12;
            13:      return SEG_CODE_13;
            14:      return SEG_CODE_14;
            default: return SEG_CODE_15;
        endcase
    endfunction
endpackage

// File: rtl/btd_decoder_seg_lut.sv
// Combinational exact-match lookup: segment pattern -> {hit, magnitude}.
module seg_lut
    import btd_pkg::*;
(
    input  logic [SEG_W-1:0] i_repr,
    output logic             o_hit,
    output logic [3:0]       o_mag
);
    logic [15:0] w_match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign w_match[gi] = (i_repr == seg_code(gi));
        end
    endgenerate

    // Codes are distinct, so at most one match bit is ever set.
    always_comb begin
        o_hit = |w_match;
        o_mag = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_match[i]) begin
                o_mag = 4'(i);
            end
        end
    end
endmodule

// File: rtl/btd_decoder.sv
// Registered signed seven-segment decoder with valid/ready handshake
// and a saturating count of illegal patterns.
module btd_decoder
    import btd_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEG_W-1:0] in_repr,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [VAL_W-1:0] out_value,
    output logic             out_err,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             r_state;
    logic [VAL_W-1:0]   r_value;
    logic               r_err;
    logic [ERR_W-1:0]   r_err_count;

    logic               w_hit;
    logic [3:0]         w_mag;
    logic               w_accept;
    logic [VAL_W-1:0]   w_value;

    seg_lut u_seg_lut (
        .i_repr (in_repr),
        .o_hit  (w_hit),
        .o_mag  (w_mag)
    );

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // Negative zero pattern stands for -16, the one value without a positive twin.
    always_comb begin
        w_value = '0;
        if (w_hit) begin
            if (!in_sign) begin
                w_value = {1'b0, w_mag};
            end else if (w_mag == 4'd0) begin
                w_value = 5'b10000;
            end else begin
                w_value = (~{1'b0, w_mag}) + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_value     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_FULL;
                ST_FULL:  if (out_ready && !w_accept) r_state <= ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
            if (w_accept) begin
                r_value <= w_value;
                r_err   <= !w_hit;
            end
            if (err_clr) begin
                r_err_count <= '0;
            end else if (w_accept && !w_hit && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign out_value = r_value;
    assign out_err   = r_err;
    assign err_count = r_err_count;
endmodule

// File: tb/tb_btd_decoder.sv
// Randomized self-checking bench for btd_decoder against a table-driven model.
module tb_btd_decoder;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [6:0] in_repr;
    logic       in_sign;
    logic       out_ready;
    logic       err_clr;

    logic       a_in_ready, a_out_valid, a_out_err;
    logic [4:0] a_out_value;
    logic [7:0] a_err_count;
    logic       b_in_ready, b_out_valid, b_out_err;
    logic [4:0] b_out_value;
    logic [1:0] b_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] codes [16] = '{7'b1110111, 7'b0010010, 7'b1011101, 7'b1011011,
                               7'b0111010, 7'b1101011, 7'b1101111, 7'b1010010,
                               7'b1111111, 7'b1111011, 7'b1111110, 7'b0101111,
                               7'b1100101, 7'b0011111, 7'b1101101, 7'b1101100};

    always #5 clk = ~clk;

    btd_decoder #(.ERR_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_repr(in_repr), .in_sign(in_sign), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_value(a_out_value), .out_err(a_out_err),
        .err_clr(err_clr), .err_count(a_err_count)
    );

    btd_decoder #(.ERR_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_repr(in_repr), .in_sign(in_sign), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_value(b_out_value), .out_err(b_out_err),
        .err_clr(err_clr), .err_count(b_err_count)
    );

    // Reference: returns {err, value} from the code table and signed arithmetic.
    function automatic logic [5:0] model(input logic [6:0] r, input logic s);
        int v;
        for (int i = 0; i < 16; i++) begin
            if (codes[i] == r) begin
                if (!s)          v = i;
                else if (i == 0) v = -16;
                else             v = -i;
                return {1'b0, 5'(v)};
            end
        end
        return 6'b100000;
    endfunction

    function automatic logic [6:0] rand_illegal();
        logic [6:0] r;
        logic [5:0] m;
        do begin
            r = 7'($urandom);
            m = model(r, 1'b0);
        end while (!m[5]);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_repr = '0; in_sign = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_out_value !== 5'd0 || a_out_err !== 1'b0 ||
            a_err_count !== 8'd0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b value=%b err=%b cnt=%0d ready=%b required 0/00000/0/0/1",
                     a_out_valid, a_out_value, a_out_err, a_err_count, a_in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_first();
        in_valid = 1'b1; in_repr = 7'b0010010; in_sign = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_value !== 5'b11111 || a_out_err !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_minus_one: valid=%b value=%b err=%b ready=%b required 1/11111/0/1",
                     a_out_valid, a_out_value, a_out_err, a_in_ready);
        end
        $display("first: repr=0010010 sign=1 -> value=%b err=%b", a_out_value, a_out_err);
        cyc();
    endtask

    task automatic test_loopback_sweep();
        int mag;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int d = -16; d < 16; d++) begin
            mag     = (d < 0) ? ((d == -16) ? 0 : -d) : d;
            in_sign = (d < 0);
            in_repr = codes[mag];
            cyc();
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_value !== 5'(d) || a_out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_%0d: valid=%b value=%b err=%b required 1/%b/0",
                         d, a_out_valid, a_out_value, a_out_err, 5'(d));
            end
            $display("sweep: data_in=%0d repr=%b sign=%b -> value=%b", d, in_repr, in_sign, a_out_value);
        end
        in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_repr = 7'b0000000; in_sign = 1'b0; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_value !== 5'd0 || a_out_err !== 1'b1 || a_err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_zero: valid=%b value=%b err=%b cnt=%0d required 1/00000/1/1",
                     a_out_valid, a_out_value, a_out_err, a_err_count);
        end
        $display("illegal: repr=0000000 -> value=%b err=%b cnt=%0d", a_out_value, a_out_err, a_err_count);
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_repr = 7'b1111111; in_sign = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            in_repr = codes[$urandom_range(15)];
            in_sign = 1'($urandom);
            cyc();
            n_checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_value !== 5'd8 || a_out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: ready=%b valid=%b value=%b err=%b required 0/1/01000/0",
                         k, a_in_ready, a_out_valid, a_out_value, a_out_err);
            end
            $display("hold: cycle %0d value=%b ready=%b", k, a_out_value, a_in_ready);
        end
        in_repr = codes[5]; in_sign = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: ready=%b required 1", a_in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_value !== 5'b11011) begin
            n_fail++;
            $display("FAIL release_accept: valid=%b value=%b required 1/11011", a_out_valid, a_out_value);
        end
        $display("release: next value=%b", a_out_value);
        cyc();
    endtask

    task automatic test_saturation();
        err_clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        err_clr = 1'b0;
        n_checks++;
        if (b_err_count !== 2'd0) begin
            n_fail++;
            $display("FAIL sat_preclear: cnt=%0d required 0", b_err_count);
        end
        in_valid = 1'b1; in_sign = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_repr = rand_illegal();
            cyc();
            n_checks++;
            if (b_err_count !== 2'((k > 3) ? 3 : k) || b_out_err !== 1'b1 || b_out_value !== 5'd0) begin
                n_fail++;
                $display("FAIL sat_%0d: cnt=%0d err=%b value=%b required %0d/1/00000",
                         k, b_err_count, b_out_err, b_out_value, (k > 3) ? 3 : k);
            end
            $display("saturate: illegal %0d repr=%b cnt=%0d", k, in_repr, b_err_count);
        end
        in_repr = rand_illegal(); err_clr = 1'b1;
        cyc();
        err_clr = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (b_err_count !== 2'd0 || a_err_count !== 8'd0 || b_out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_priority: cntB=%0d cntA=%0d err=%b required 0/0/1",
                     b_err_count, a_err_count, b_out_err);
        end
        $display("clear+illegal: cntB=%0d cntA=%0d", b_err_count, a_err_count);
        cyc();
    endtask

    task automatic test_random();
        logic [5:0] q[$];
        logic [5:0] m;
        int cnt = 0;
        bit exp_ready;
        for (int t = 0; t < 300; t++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_sign   = 1'($urandom);
            in_repr   = ($urandom_range(3) == 0) ? rand_illegal() : codes[$urandom_range(15)];
            #1;
            exp_ready = (q.size() == 0) || out_ready;
            n_checks++;
            if (a_in_ready !== exp_ready || a_out_valid !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_hs_%0d: ready=%b valid=%b required %b/%b",
                         t, a_in_ready, a_out_valid, exp_ready, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if ({a_out_err, a_out_value} !== q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data_%0d: err/value=%b required %b", t, {a_out_err, a_out_value}, q[0]);
                end
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ready) begin
                m = model(in_repr, in_sign);
                q.push_back(m);
                if (m[5] && cnt < 255) cnt++;
                $display("random: t=%0d accept repr=%b sign=%b expect err/value=%b", t, in_repr, in_sign, m);
            end
            cyc();
            n_checks++;
            if (a_err_count !== 8'(cnt)) begin
                n_fail++;
                $display("FAIL rnd_cnt_%0d: cnt=%0d required %0d", t, a_err_count, cnt);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; in_repr = 7'b0000000; in_sign = 1'b0; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_err_count === 8'd0) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b cnt=%0d required 1/nonzero", a_out_valid, a_err_count);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_err_count !== 8'd0 || a_out_err !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b cnt=%0d err=%b ready=%b required 0/0/0/1",
                     a_out_valid, a_err_count, a_out_err, a_in_ready);
        end
        $display("async reset: valid=%b cnt=%0d", a_out_valid, a_err_count);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_repr = codes[9]; in_sign = 1'b1;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_value !== 5'b10111 || a_out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_accept: valid=%b value=%b err=%b required 1/10111/0",
                     a_out_valid, a_out_value, a_out_err);
        end
        $display("post reset: value=%b", a_out_value);
        cyc();
    endtask

    initial begin
        test_reset();
        test_first();
        test_loopback_sweep();
        test_illegal();
        test_backpressure();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
